order_uart_rx: RTL



---
 rtl/order_uart_rx.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/order_uart_rx.sv
// UART order intake: 8N1 byte receiver feeding an A5/side/price/checksum packet parser.
// Optional even-parity framing (8E1) is enabled with `define ORDER_UART_RX_PARITY_EN.
module order_uart_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] buy_price,
  output logic [7:0] sell_price,
  output logic       order_valid,
  output logic       order_side,
  output logic [7:0] err_count,
  output logic       rx_busy
);

  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int TO_CYC = TIMEOUT_BITS * CPB;
  localparam int BTW    = $clog2(CPB + 1);
  localparam int TOW    = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {
    B_IDLE, B_START, B_DATA, B_PARITY, B_STOP, B_WAIT_HI
  } bstate_t;

  typedef enum logic [1:0] {
    P_SYNC, P_SIDE, P_PRICE, P_CSUM
  } pstate_t;

  logic           rx_meta_q, rx_s_q;
  bstate_t        bst_q, bst_d;
  logic [BTW-1:0] tmr_q, tmr_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     sh_q, sh_d;
  logic           byte_done_q, byte_done_d;
  logic           ferr_q, ferr_d;
  logic           par_bad_q;
`ifdef ORDER_UART_RX_PARITY_EN
  logic           par_bad_d;
`endif

  pstate_t        pst_q, pst_d;
  logic           side_q, side_d;
  logic [7:0]     price_q, price_d;
  logic [TOW-1:0] to_q, to_d;
  logic           acc_q, acc_d;
  logic [7:0]     buy_q, buy_d, sell_q, sell_d;
  logic           oside_q, oside_d;
  logic           valid_q, valid_d;
  logic [7:0]     errc_q, errc_d;
  logic           err_inc;

  // Byte receiver
  always_comb begin
    bst_d       = bst_q;
    tmr_d       = tmr_q + 1'b1;
    idx_d       = idx_q;
    sh_d        = sh_q;
    byte_done_d = 1'b0;
    ferr_d      = 1'b0;
`ifdef ORDER_UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif
    case (bst_q)
      B_IDLE: begin
        tmr_d = '0;
        if (!rx_s_q) bst_d = B_START;
      end
      B_START: begin
        if (tmr_q == BTW'(HALF - 1)) begin
          tmr_d = '0;
          idx_d = 3'd0;
          bst_d = rx_s_q ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (tmr_q == BTW'(CPB - 1)) begin
          tmr_d = '0;
          sh_d  = {rx_s_q, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef ORDER_UART_RX_PARITY_EN
            bst_d = B_PARITY;
`else
            bst_d = B_STOP;
`endif
          end
        end
      end
`ifdef ORDER_UART_RX_PARITY_EN
      B_PARITY: begin
        if (tmr_q == BTW'(CPB - 1)) begin
          tmr_d     = '0;
          par_bad_d = (^sh_q) ^ rx_s_q;
          bst_d     = B_STOP;
        end
      end
`endif
      B_STOP: begin
        if (tmr_q == BTW'(CPB - 1)) begin
          tmr_d = '0;
          if (rx_s_q) begin
            // A parity failure drops the byte and reports like a framing error.
            bst_d       = B_IDLE;
            byte_done_d = !par_bad_q;
            ferr_d      = par_bad_q;
          end else begin
            bst_d  = B_WAIT_HI;
            ferr_d = 1'b1;
          end
        end
      end
      B_WAIT_HI: begin
        tmr_d = '0;
        if (rx_s_q) bst_d = B_IDLE;
      end
      default: bst_d = B_IDLE;
    endcase
  end

  // Packet parser and output registers
  always_comb begin
    pst_d   = pst_q;
    side_d  = side_q;
    price_d = price_q;
    to_d    = to_q;
    acc_d   = 1'b0;
    err_inc = 1'b0;
    buy_d   = buy_q;
    sell_d  = sell_q;
    oside_d = oside_q;
    valid_d = 1'b0;
    errc_d  = errc_q;

    if (acc_q) begin
      valid_d = 1'b1;
      oside_d = side_q;
      if (side_q) buy_d = price_q;
      else        sell_d = price_q;
    end

    if (pst_q == P_SYNC)      to_d = '0;
    else if (bst_q == B_IDLE) to_d = to_q + 1'b1;

    if (byte_done_q) begin
      to_d = '0;
      case (pst_q)
        P_SYNC:  if (sh_q == 8'hA5) pst_d = P_SIDE;
        P_SIDE: begin
          if (sh_q == 8'h42 || sh_q == 8'h53) begin
            side_d = (sh_q == 8'h42);
            pst_d  = P_PRICE;
          end else begin
            err_inc = 1'b1;
            pst_d   = P_SYNC;
          end
        end
        P_PRICE: begin
          price_d = sh_q;
          pst_d   = P_CSUM;
        end
        P_CSUM: begin
          if (sh_q == ((side_q ? 8'h42 : 8'h53) ^ price_q)) acc_d = 1'b1;
          else                                              err_inc = 1'b1;
          pst_d = P_SYNC;
        end
        default: pst_d = P_SYNC;
      endcase
    end else if (ferr_q) begin
      err_inc = 1'b1;
      pst_d   = P_SYNC;
      to_d    = '0;
    end else if (pst_q != P_SYNC && to_q >= TOW'(TO_CYC)) begin
      err_inc = 1'b1;
      pst_d   = P_SYNC;
      to_d    = '0;
    end

    if (err_inc && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      bst_q       <= B_IDLE;
      tmr_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      byte_done_q <= 1'b0;
      ferr_q      <= 1'b0;
      pst_q       <= P_SYNC;
      side_q      <= 1'b0;
      price_q     <= '0;
      to_q        <= '0;
      acc_q       <= 1'b0;
      buy_q       <= '0;
      sell_q      <= '0;
      oside_q     <= 1'b0;
      valid_q     <= 1'b0;
      errc_q      <= '0;
    end else begin
      rx_meta_q   <= uart_rxd;
      rx_s_q      <= rx_meta_q;
      bst_q       <= bst_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      byte_done_q <= byte_done_d;
      ferr_q      <= ferr_d;
      pst_q       <= pst_d;
      side_q      <= side_d;
      price_q     <= price_d;
      to_q        <= to_d;
      acc_q       <= acc_d;
      buy_q       <= buy_d;
      sell_q      <= sell_d;
      oside_q     <= oside_d;
      valid_q     <= valid_d;
      errc_q      <= errc_d;
    end
  end

`ifdef ORDER_UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_bad_q <= 1'b0;
    else       par_bad_q <= par_bad_d;
  end
`else
  assign par_bad_q = 1'b0;
`endif

  assign buy_price   = buy_q;
  assign sell_price  = sell_q;
  assign order_valid = valid_q;
  assign order_side  = oside_q;
  assign err_count   = errc_q;
  assign rx_busy     = (bst_q != B_IDLE);

endmodule
